// File: rtl/load_size_unit_pkg.sv
// Shared encodings for the load/store sub-word path: access size codes used by
// both the store merge selector and the load extractor, plus load FSM states.
package load_size_unit_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/load_size_unit_extract.sv
// Combinational size-based extraction from the low lanes of a memory word.
// Build option SIGN_EXT_EN: sign-extend halfword/byte results instead of zero-extending.
module load_extract
  import load_size_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (size)
      SZ_WORD: result = data;
`ifdef SIGN_EXT_EN
      SZ_HALF: result = {{16{data[15]}}, data[15:0]};
      SZ_BYTE: result = {{24{data[7]}}, data[7:0]};
`else
      SZ_HALF: result = {16'b0, data[15:0]};
      SZ_BYTE: result = {24'b0, data[7:0]};
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_size_unit.sv
// Load side of the sub-word access path: issues a word read, waits MEM_LATENCY
// cycles, then returns the extracted result. Build option: SIGN_EXT_EN (see load_extract).
module load_size_unit
  import load_size_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] data_out
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]  size_reg, size_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] data_reg, data_next;
  logic        err_reg, err_next;
  logic [31:0] ext_data;

  load_extract u_extract (
    .size   (size_reg),
    .data   (mem_data),
    .result (ext_data)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    size_next     = size_reg;
    mem_addr_next = mem_addr_reg;
    data_next     = data_reg;
    err_next      = err_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        err_next   = 1'b0;
        state_next = ST_IDLE;
        if (start) begin
          if (size != SZ_ILL) begin
            state_next    = ST_WAIT;
            mem_addr_next = addr;
            size_next     = size;
            cnt_next      = CW'(MEM_LATENCY - 1);
          end else begin
            // Illegal size completes immediately without touching memory.
            state_next = ST_DONE;
            err_next   = 1'b1;
            data_next  = '0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          data_next  = ext_data;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      size_reg     <= SZ_WORD;
      mem_addr_reg <= '0;
      data_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      size_reg     <= size_next;
      mem_addr_reg <= mem_addr_next;
      data_reg     <= data_next;
      err_reg      <= err_next;
    end
  end

  assign mem_addr = mem_addr_reg;
  assign mem_rd   = (state_reg == ST_WAIT);
  assign busy     = (state_reg == ST_WAIT);
  assign done     = (state_reg == ST_DONE);
  assign err      = err_reg;
  assign data_out = data_reg;

endmodule

// File: tb/tb_load_size_unit.sv
// Scoreboard bench for load_size_unit: stimulus queues expected completions,
// a negedge monitor pops and compares whenever done is presented.
module tb_load_size_unit;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  size = '0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;
  logic        busy, done, err;
  logic [31:0] data_out;

  logic [31:0] mem_word = '0;
  int          run = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];

  load_size_unit #(.MEM_LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .addr     (addr),
    .size     (size),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: the word is only valid LAT cycles into a read burst.
  always @(posedge clk) run <= mem_rd ? run + 1 : 0;
  assign mem_data = (mem_rd && run == LAT - 1) ? mem_word : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with data_out=%h expected no done (cyc %0d)", data_out, cyc);
      end else begin
        e = q.pop_front();
        $display("txn cyc=%0d data_out=%h err=%b", cyc, data_out, err);
        check("done_cycle", cyc, e.cyc);
        check("data_out", data_out, e.data);
        check("err", {31'b0, err}, {31'b0, e.err});
        check("done_busy", {31'b0, busy}, 32'd0);
        check("done_mem_rd", {31'b0, mem_rd}, 32'd0);
      end
    end else if (q.size() != 0 && cyc > q[0].cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_done: got no done expected one at cyc %0d (now %0d)", e.cyc, cyc);
    end
  end

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] word,
                      input logic [31:0] exp_data, input logic exp_err);
    int c;
    @(posedge clk); #1;
    mem_word = word;
    start = 1'b1;
    addr = a;
    size = sz;
    c = cyc;
    q.push_back('{data: exp_data, err: exp_err, cyc: exp_err ? c + 1 : c + LAT + 1});
    @(posedge clk); #1;
    start = 1'b0;
    if (exp_err) begin
      @(negedge clk);
      check("illegal_no_rd", {31'b0, mem_rd}, 32'd0);
    end else begin
      for (int k = 1; k <= LAT; k++) begin
        @(negedge clk);
        check("wait_mem_rd", {31'b0, mem_rd}, 32'd1);
        check("wait_busy", {31'b0, busy}, 32'd1);
        check("wait_mem_addr", mem_addr, a);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_data_out", data_out, 32'd0);

    load(32'h0000_0040, 2'b00, 32'h8765_4321, 32'h8765_4321, 1'b0);
`ifdef SIGN_EXT_EN
    load(32'h0000_0080, 2'b01, 32'h1234_F00D, 32'hFFFF_F00D, 1'b0);
    load(32'h0000_0084, 2'b10, 32'hAABB_CC80, 32'hFFFF_FF80, 1'b0);
`else
    load(32'h0000_0080, 2'b01, 32'h1234_F00D, 32'h0000_F00D, 1'b0);
    load(32'h0000_0084, 2'b10, 32'hAABB_CC80, 32'h0000_0080, 1'b0);
`endif
    load(32'h0000_0088, 2'b01, 32'h89AB_7FFF, 32'h0000_7FFF, 1'b0);
    load(32'h0000_0043, 2'b10, 32'h1234_5678, 32'h0000_0078, 1'b0);
    load(32'h0000_0090, 2'b11, 32'h5555_5555, 32'h0000_0000, 1'b1);

    // Start held high: one accepted load per LAT+1 cycles.
    @(posedge clk); #1;
    mem_word = 32'h1122_3344;
    start = 1'b1;
    addr = 32'h0000_0100;
    size = 2'b00;
    c = cyc;
    for (int k = 1; k <= 3; k++)
      q.push_back('{data: 32'h1122_3344, err: 1'b0, cyc: c + 3 * k});
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("held_mem_rd", {31'b0, mem_rd}, {31'b0, (k % 3) != 0});
      check("held_busy", {31'b0, busy}, {31'b0, (k % 3) != 0});
    end
    start = 1'b0;

    // Reset in the second wait cycle discards the load.
    @(posedge clk); #1;
    mem_word = 32'hCAFE_F00D;
    start = 1'b1;
    addr = 32'h0000_0200;
    size = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_mem_rd", {31'b0, mem_rd}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    check("mrst_data_out", data_out, 32'd0);
    check("mrst_mem_addr", mem_addr, 32'd0);
    repeat (8) @(posedge clk);

    @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
